// File: rtl/busarb_pkg.sv
// Shared FSM type and default bus widths for the firmware-ROM bus arbiter.
package busarb_pkg;

    localparam int BUS_AD_LEN = 32;
    localparam int BUS_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } busarb_state_t;

endpackage

// File: rtl/busarb_rr.sv
// Combinational rotating-priority picker: first set request at or after rr_ptr.
module busarb_rr #(
    parameter int NREQ  = 2,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic             any_req,
    output logic [IDX_W-1:0] winner,
    output logic [NREQ-1:0]  winner_oh
);

    localparam int SUM_W = IDX_W + 1;

    logic [NREQ-1:0]  rot_s;
    logic [SUM_W-1:0] off_s;
    logic [SUM_W-1:0] sum_s;

    // Bit j of rot_s is requester (rr_ptr + j) mod NREQ; the lowest set bit wins.
    always_comb begin
        rot_s   = NREQ'({req, req} >> rr_ptr);
        any_req = |req;
        off_s   = '0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            off_s = rot_s[j] ? SUM_W'(j) : off_s;
        end
        sum_s = {1'b0, rr_ptr} + off_s;
        if (sum_s >= SUM_W'(NREQ)) begin
            winner = IDX_W'(sum_s - SUM_W'(NREQ));
        end else begin
            winner = IDX_W'(sum_s);
        end
        for (int j = 0; j < NREQ; j++) begin
            winner_oh[j] = any_req & (winner == IDX_W'(j));
        end
    end

endmodule

// File: rtl/busarb.sv
// Round-robin arbiter sharing one single-outstanding read path to the firmware ROM.
module busarb
    import busarb_pkg::*;
#(
    parameter int AD_LEN    = BUS_AD_LEN,
    parameter int BUS_WIDTH = BUS_DATA_W,
    parameter int NREQ      = 2,
    parameter int RD_LAT    = 1
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [NREQ-1:0]        req_i,
    input  logic [NREQ*AD_LEN-1:0] ad_i,
    output logic [NREQ-1:0]        gnt_o,
    output logic [NREQ-1:0]        rvalid_o,
    output logic [BUS_WIDTH-1:0]   rdata_o,
    output logic [AD_LEN-1:0]      bus_ad_o,
    input  logic [BUS_WIDTH-1:0]   bus_data_i,
    output logic                   busy_o
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int CNT_W = $clog2(RD_LAT + 1);

    busarb_state_t        state_r;
    busarb_state_t        state_s;
    logic [CNT_W-1:0]     cnt_r;
    logic [CNT_W-1:0]     cnt_s;
    logic [IDX_W-1:0]     rr_ptr_r;
    logic [IDX_W-1:0]     rr_ptr_s;
    logic [NREQ-1:0]      owner_r;
    logic [NREQ-1:0]      owner_s;
    logic [AD_LEN-1:0]    bus_ad_r;
    logic [AD_LEN-1:0]    bus_ad_s;
    logic [BUS_WIDTH-1:0] rdata_r;
    logic [BUS_WIDTH-1:0] rdata_s;
    logic [NREQ-1:0]      gnt_r;
    logic [NREQ-1:0]      gnt_s;
    logic [NREQ-1:0]      rvalid_r;
    logic [NREQ-1:0]      rvalid_s;
    logic                 any_req_s;
    logic                 launch_s;
    logic                 capture_s;
    logic [IDX_W-1:0]     winner_s;
    logic [IDX_W-1:0]     rr_next_s;
    logic [NREQ-1:0]      winner_oh_s;
    logic [AD_LEN-1:0]    sel_ad_s;

    busarb_rr #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req       (req_i),
        .rr_ptr    (rr_ptr_r),
        .any_req   (any_req_s),
        .winner    (winner_s),
        .winner_oh (winner_oh_s)
    );

    // Winner's address through a one-hot AND-OR mux, and the pointer one past the winner.
    always_comb begin
        sel_ad_s = '0;
        for (int j = 0; j < NREQ; j++) begin
            sel_ad_s = sel_ad_s | (ad_i[j*AD_LEN +: AD_LEN] & {AD_LEN{winner_oh_s[j]}});
        end
        if (winner_s == IDX_W'(NREQ - 1)) begin
            rr_next_s = '0;
        end else begin
            rr_next_s = winner_s + IDX_W'(1);
        end
    end

    // FSM: IDLE and RESP both arbitrate, so RESP overlaps the next grant; WAIT counts down.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        launch_s  = 1'b0;
        capture_s = 1'b0;
        case (state_r)
            IDLE, RESP: begin
                launch_s = any_req_s;
                if (any_req_s) begin
                    state_s = ADDR;
                    cnt_s   = CNT_W'(RD_LAT);
                end else begin
                    state_s = IDLE;
                end
            end
            ADDR: begin
                state_s = WAIT;
            end
            WAIT: begin
                if (cnt_r != '0) begin
                    cnt_s = cnt_r - CNT_W'(1);
                end else begin
                    cnt_s = '0;
                end
                // A zero count cannot occur here; treating it as the last cycle avoids a hang.
                if (cnt_r <= CNT_W'(1)) begin
                    capture_s = 1'b1;
                    state_s   = RESP;
                end else begin
                    state_s = WAIT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Datapath next values: grant/address/owner on launch, data/valid on capture.
    always_comb begin
        gnt_s    = launch_s ? winner_oh_s : '0;
        bus_ad_s = launch_s ? sel_ad_s : bus_ad_r;
        rr_ptr_s = launch_s ? rr_next_s : rr_ptr_r;
        owner_s  = launch_s ? winner_oh_s : owner_r;
        rvalid_s = capture_s ? owner_r : '0;
        rdata_s  = capture_s ? bus_data_i : rdata_r;
    end

    // State and output registers; reset discards any response still in flight.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_r  <= IDLE;
            cnt_r    <= '0;
            rr_ptr_r <= '0;
            owner_r  <= '0;
            bus_ad_r <= '0;
            rdata_r  <= '0;
            gnt_r    <= '0;
            rvalid_r <= '0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            rr_ptr_r <= rr_ptr_s;
            owner_r  <= owner_s;
            bus_ad_r <= bus_ad_s;
            rdata_r  <= rdata_s;
            gnt_r    <= gnt_s;
            rvalid_r <= rvalid_s;
        end
    end

    assign gnt_o    = gnt_r;
    assign rvalid_o = rvalid_r;
    assign rdata_o  = rdata_r;
    assign bus_ad_o = bus_ad_r;
    assign busy_o   = (state_r != IDLE);

endmodule

// File: doc/busarb.md
# busarb

Uncore bus arbiter placed in front of the bus control unit. It shares the single read path into the platform firmware ROM among NREQ requesters, such as instruction fetch and load/store. Only one transaction is outstanding at a time. Requesters are granted in round-robin order, and each read response is returned to the requester that issued it.

## Interface
Parameters:
- AD_LEN, 32, address width; matches the bus control unit.
- BUS_WIDTH, 32, data width; matches the bus control unit.
- NREQ, 2, number of requesters; must be 2 or more.
- RD_LAT, 1, read latency of the bus target in cycles; must be 1 or more.

Ports:
- clk_i  in  1  single clock; all state updates on rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- req_i  in  NREQ  per-requester read request, level.
- ad_i  in  NREQ*AD_LEN  per-requester address; requester n occupies bits [n*AD_LEN +: AD_LEN].
- gnt_o  out  NREQ  one-hot grant, one-cycle pulse.
- rvalid_o  out  NREQ  one-hot response valid, one-cycle pulse.
- rdata_o  out  BUS_WIDTH  response data, shared by all requesters.
- bus_ad_o  out  AD_LEN  address to the bus control unit `ad_i`.
- bus_data_i  in  BUS_WIDTH  data from the bus control unit `data_o`.
- busy_o  out  1  high whenever the state is not IDLE.

## Operation
- The FSM has four states: IDLE, ADDR, WAIT and RESP.
- **IDLE:** if any bit of req_i is set, the picker selects a winner and the next state is ADDR.
  - The picker chooses the first set bit at or after rr_ptr, scanning upward and wrapping at NREQ-1 to 0.
- **Entry to ADDR:**
  - bus_ad_o <= ad_i[winner].
  - gnt_o[winner] = 1 for exactly that cycle.
  - cnt <= RD_LAT.
  - rr_ptr <= (winner+1) mod NREQ.
- **ADDR:** the next state is always WAIT.
- **WAIT:**
  - cnt decrements by 1 each cycle.
  - In the cycle where cnt == 1, rdata_o <= bus_data_i and the next state is RESP.
  - cnt is $clog2(RD_LAT+1) bits wide and never underflows.
- **RESP:**
  - rvalid_o[owner] = 1 for one cycle, where owner is the winner registered at ADDR.
  - RESP arbitrates exactly like IDLE. If any request is pending, the next state is ADDR, giving back-to-back transactions. Otherwise the next state is IDLE.
- **Requester rule:** a requester holds req_i and its ad_i stable until it sees gnt_o.
  - ad_i may change in the cycle after the grant, because the address is latched at ADDR entry.
  - Keeping req_i high after the grant requests another transaction.
- **Dropped request:** if req_i is deasserted before it is sampled in IDLE or RESP, no transaction occurs and no rvalid_o is produced.
- **Simultaneous requests:** the rr_ptr order decides. After reset rr_ptr = 0, so requester 0 wins first.
- **Output hold:** bus_ad_o and rdata_o hold their last values until the next update. gnt_o and rvalid_o are 0 outside their pulse cycles.
- **Reset:** reset_i low at any time, including mid-transaction, takes effect immediately:
  - state = IDLE, rr_ptr = 0, cnt = 0.
  - gnt_o = 0, rvalid_o = 0, busy_o = 0.
  - bus_ad_o = 0, rdata_o = 0.
  - An in-flight response is discarded and never delivered.

## Timing
- Take cycle 0 as the cycle in which a request is sampled in IDLE:
  - gnt_o and the new bus_ad_o appear in cycle 1 (ADDR).
  - WAIT occupies cycles 2 to RD_LAT+1.
  - rvalid_o and rdata_o are valid in cycle RD_LAT+2.
- For RD_LAT = 1: grant in cycle 1, capture at the end of cycle 2, rvalid_o in cycle 3.
- Back-to-back throughput is one transaction every RD_LAT+2 cycles. RESP overlaps with the arbitration for the next transaction.
- All outputs are registered; there is no combinational path from req_i to gnt_o.
- The ROM samples bus_ad_o at the rising edge that ends ADDR.

## Structure
- `busarb_pkg` holds:
  - the FSM state enum `busarb_state_t` (IDLE, ADDR, WAIT, RESP);
  - a shared `BUS_AD_LEN` / `BUS_DATA_W` pair of default constants, also used by the bus control unit.
- One sub-module, `busarb_rr`:
  - combinational rotating priority picker;
  - inputs: req vector and rr_ptr;
  - outputs: any_req, and winner index plus a one-hot vector.
- Top level: the FSM, cnt, rr_ptr, the address/owner registers and the data capture register.

## Test plan
- **Reset mid-operation:** assert reset_i low during WAIT -> all outputs 0 immediately. After release, no rvalid_o for the aborted transaction.
- **Single read:** NREQ=2, RD_LAT=1, req_i=2'b01, ad_i[0]=32'h10, target returns 32'hDEAD_BEEF -> gnt_o=01 in cycle 1, bus_ad_o=32'h10, rvalid_o=01 in cycle 3, rdata_o=32'hDEAD_BEEF.
- **Simultaneous requests:** req_i=2'b11 held continuously from reset -> grants alternate 01, 10, 01, 10, spaced 3 cycles apart. Each rvalid_o goes to the matching owner with the matching data.
- **Latency sweep:** RD_LAT=3 -> rvalid_o exactly 5 cycles after the request is sampled, and bus_data_i is captured only on the cnt==1 cycle.
- **Address change after grant:** change ad_i[1] the cycle after gnt_o[1] -> bus_ad_o keeps the latched address until the next ADDR.
- **Dropped request:** req_i pulsed for one cycle while the FSM is busy, then dropped -> no grant and no response for that requester.
